// File: rtl/serial_ascii_b64_if.sv
// Bus between a serial ASCII bit source and the Base64 assembler: stream bit,
// its position and length in, assembled character / sextet / Base64 glyph out.
interface serial_ascii_b64_if #(
  parameter int IDX_W = 10
);
  logic             bit_in;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] len;
  logic [6:0]       ascii;
  logic [6:0]       bas;
  logic [5:0]       out;

  modport master (output bit_in, output index, output len,
                  input  ascii,  input  bas,   input  out);
  modport slave  (input  bit_in, input  index, input  len,
                  output ascii,  output bas,   output out);
endinterface

// File: rtl/serial_ascii_b64.sv
// Serial MSB-first 7-bit ASCII assembler with a parallel Base64 sextet encoder.
// Define B64_URLSAFE_EN to emit '-' and '_' for codes 62/63 instead of '+' and '/'.
module serial_ascii_b64 #(
   parameter int IDX_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   serial_ascii_b64_if.slave  bus
);
   localparam int CHAR_W = 7;
   localparam int SEXT_W = 6;

   typedef enum logic {S_RUN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [IDX_W-1:0]  index, len;
   logic              accept, last;
   logic [CHAR_W-2:0] char_sr;
   logic [2:0]        cnt7;
   logic [SEXT_W-2:0] sext_sr;
   logic [2:0]        cnt6;
   logic [SEXT_W-1:0] sext_cur, sext_val;
   logic [CHAR_W-1:0] ascii_q, bas_q;
   logic [SEXT_W-1:0] out_q;

   function automatic logic [6:0] b64_map(input logic [5:0] v);
      if (v < 6'd26)      return 7'h41 + 7'(v);
      else if (v < 6'd52) return 7'h61 + 7'(v - 6'd26);
      else if (v < 6'd62) return 7'h30 + 7'(v - 6'd52);
`ifdef B64_URLSAFE_EN
      else if (v == 6'd62) return 7'h2D;
      else                 return 7'h5F;
`else
      else if (v == 6'd62) return 7'h2B;
      else                 return 7'h2F;
`endif
   endfunction

   assign index  = bus.index;
   assign len    = bus.len;
   assign accept = (state == S_RUN) && (index < len);
   assign last   = accept && (index == '0);

   // Only the low cnt6+1 bits of sext_cur are this sextet's; shifting
   // left-justifies them and pushes stale upper bits out.
   assign sext_cur = {sext_sr, bus.bit_in};
   assign sext_val = sext_cur << (3'd5 - cnt6);

   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (last) state_nxt = S_DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         char_sr <= '0;
         cnt7    <= '0;
         sext_sr <= '0;
         cnt6    <= '0;
         ascii_q <= '0;
         bas_q   <= '0;
         out_q   <= '0;
      end else if (accept) begin
         char_sr <= {char_sr[CHAR_W-3:0], bus.bit_in};
         if (cnt7 == 3'd6) begin
            ascii_q <= {char_sr, bus.bit_in};
            cnt7    <= '0;
         end else begin
            cnt7 <= cnt7 + 3'd1;
         end

         sext_sr <= sext_cur[SEXT_W-2:0];
         cnt6    <= (cnt6 == 3'd5) ? 3'd0 : cnt6 + 3'd1;
         if (cnt6 == 3'd5 || last) begin
            out_q <= sext_val;
            bas_q <= b64_map(sext_val);
         end
      end
   end

   assign bus.ascii = ascii_q;
   assign bus.bas   = bas_q;
   assign bus.out   = out_q;
endmodule

// File: tb/tb_serial_ascii_b64.sv
// Randomized and directed bench for serial_ascii_b64, checked against a
// bit-queue reference model of accepted stream bits.
module tb_serial_ascii_b64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   serial_ascii_b64_if #(.IDX_W(10)) bus();
   serial_ascii_b64 #(.IDX_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

`ifdef B64_URLSAFE_EN
   string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789-_";
`else
   string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
`endif
   string msg = "COMP311_is_fun";

   // Reference model: every accepted bit since reset, plus the stream-ended flag
   bit q[$];
   bit m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      int n, nc, ns, rem;
      logic [6:0] ea, eb;
      logic [5:0] eo;
      n = q.size(); nc = n / 7; ns = n / 6; rem = n % 6;
      ea = '0; eo = '0; eb = '0;
      if (nc > 0) for (int i = 0; i < 7; i++) ea = {ea[5:0], q[(nc-1)*7 + i]};
      if (m_done && rem != 0) begin
         for (int i = 0; i < rem; i++) eo[5-i] = q[ns*6 + i];
         eb = alpha[eo][6:0];
      end else if (ns > 0) begin
         for (int i = 0; i < 6; i++) eo = {eo[4:0], q[(ns-1)*6 + i]};
         eb = alpha[eo][6:0];
      end
      chk("model_ascii", 32'(bus.ascii), 32'(ea));
      chk("model_out",   32'(bus.out),   32'(eo));
      chk("model_bas",   32'(bus.bas),   32'(eb));
   endtask

   task automatic step(input logic b, input logic [9:0] idx, input logic [9:0] ln);
      bus.bit_in = b; bus.index = idx; bus.len = ln;
      @(posedge clk);
      if (!rst && !m_done && idx < ln) begin
         q.push_back(b);
         if (idx == 10'd0) m_done = 1'b1;
      end
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      q.delete(); m_done = 1'b0;
      rst = 1'b0;
      chk("rst_ascii", 32'(bus.ascii), 32'd0);
      chk("rst_out",   32'(bus.out),   32'd0);
      chk("rst_bas",   32'(bus.bas),   32'd0);
   endtask

   initial begin
      bit stream[$];
      logic [7:0] c;
      int ln, idx;
      bus.bit_in = 1'b0; bus.index = '0; bus.len = '0;
      m_done = 1'b0;
      do_reset();

      // Directed message stream, MSB first
      for (int k = 0; k < msg.len(); k++) begin
         c = msg[k];
         for (int j = 6; j >= 0; j--) stream.push_back(c[j]);
      end
      for (int i = 0; i < 98; i++) begin
         step(stream[i], 10'(97 - i), 10'd98);
         if (i % 7 == 6) begin
            c = msg[i/7];
            chk("msg_ascii", 32'(bus.ascii), 32'(c[6:0]));
         end
         if (i == 5)  begin chk("sext1_out", 32'(bus.out), 32'd33); chk("sext1_bas", 32'(bus.bas), 32'h68); end
         if (i == 11) begin chk("sext2_out", 32'(bus.out), 32'd51); chk("sext2_bas", 32'(bus.bas), 32'h7A); end
         if (i == 17) begin chk("sext3_out", 32'(bus.out), 32'd57); chk("sext3_bas", 32'(bus.bas), 32'h35); end
      end
      chk("final_out",   32'(bus.out),   32'd32);
      chk("final_bas",   32'(bus.bas),   32'h67);
      chk("final_ascii", 32'(bus.ascii), 32'h6E);
      // Post-done: wrapped index and unknown bit must change nothing
      step(1'bx, 10'd1023, 10'd98);
      step(1'b1, 10'd5, 10'd98);
      step(1'b0, 10'd0, 10'd98);
      chk("done_hold_out", 32'(bus.out), 32'd32);

      // Reset mid-activity then out-of-range index with toggling bit
      step(1'b1, 10'd20, 10'd30);
      do_reset();
      for (int i = 0; i < 6; i++) step(1'(i), (i % 2) ? 10'd30 : 10'd400, 10'd30);
      chk("oob_out", 32'(bus.out), 32'd0);

      // Alphabet edges
      do_reset();
      stream.delete();
      for (int i = 0; i < 12; i++) stream.push_back((i == 5) ? 1'b0 : 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(stream[i], 10'(11 - i), 10'd12);
`ifdef B64_URLSAFE_EN
         if (i == 5)  chk("edge62_bas", 32'(bus.bas), 32'h2D);
         if (i == 11) chk("edge63_bas", 32'(bus.bas), 32'h5F);
`else
         if (i == 5)  chk("edge62_bas", 32'(bus.bas), 32'h2B);
         if (i == 11) chk("edge63_bas", 32'(bus.bas), 32'h2F);
`endif
         if (i == 5)  chk("edge62_out", 32'(bus.out), 32'd62);
         if (i == 11) chk("edge63_out", 32'(bus.out), 32'd63);
      end

      // len = 0: nothing is ever accepted
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 10'(i), 10'd0);

      // Randomized streams with idle gaps, stray indices and occasional resets
      for (int r = 0; r < 40; r++) begin
         do_reset();
         ln = $urandom_range(1, 90);
         idx = ln - 1;
         while (idx >= 0) begin
            if ($urandom_range(0, 4) == 0)
               step(1'($urandom_range(0, 1)), 10'(ln + $urandom_range(0, 900)), 10'(ln));
            else begin
               step(1'($urandom_range(0, 1)), 10'(idx), 10'(ln));
               idx--;
            end
            if ($urandom_range(0, 150) == 0) begin
               do_reset();
               idx = ln - 1;
            end
         end
         for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 10'(ln));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_ascii_b64.md
Name: serial_ascii_b64

Overview:
- Serial-to-parallel ASCII assembler plus Base64 encoder.
- Consumes a 7-bit-per-character ASCII bitstream, MSB first, one bit per clock. Position is given by a down-counting index, and total length by len.
- Presents the last complete 7-bit character, the last 6-bit Base64 sextet, and that sextet's Base64 ASCII character.
- Sits between a serial bit source and a character display/transmit stage.

Parameters:
- IDX_W, 10, width of index and len.
- CHAR_W, 7, ASCII character width; fixed at 7.
- SEXT_W, 6, Base64 group width; fixed at 6.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- ascii  out  7  last fully assembled ASCII character.
- bas  out  7  Base64 alphabet character for `out`.
- out  out  6  last completed (or final zero-padded) Base64 sextet value.
- bit_in  in  1  current stream bit, equal to bitstream[index].
- index  in  IDX_W  position of bit_in. Counts down; MSB of stream is index=len-1, last bit is index=0.
- len  in  IDX_W  total stream length in bits.

Behaviour:
- Reset: synchronous, active-high, sampled on rising clk edge.
  - ascii, bas, out, internal shift registers, bit counters and done flag all clear to 0.
  - Reset mid-stream discards any partial character or sextet.
- Bit acceptance: on each rising edge, bit_in is accepted iff rst=0, done=0 and index < len.
  - Otherwise no state changes; this covers index=len, index wrapped above len, and X/idle.
- Character path:
  - Accepted bits shift left into a 7-bit char register; cnt7 increments 0..6.
  - On the edge accepting the 7th bit (cnt7=6), ascii <= {char[5:0], bit_in} and cnt7 <= 0.
  - ascii holds otherwise. It becomes visible the cycle after the 7th bit.
- Sextet path:
  - Accepted bits shift into a 6-bit register; cnt6 increments 0..5.
  - On the 6th bit (cnt6=5), out <= {sext[4:0], bit_in}, bas <= map(that value), and cnt6 <= 0.
- Final bit (accepted with index=0):
  - Character path completes normally if it lands on a 7-bit boundary. A trailing partial character is discarded and ascii holds.
  - If the sextet is partial (k = cnt6+1 collected bits, k<6), out <= the k bits left-justified, zero-padded on the right. bas <= map(out).
  - done <= 1 and stays set until reset; all further bits are ignored.
- Simultaneous char and sextet completion (every 42 bits): both update on the same edge.
- Base64 map(v), 7-bit result:
  - 0..25 -> 0x41+v ('A'-'Z').
  - 26..51 -> 0x61+(v-26) ('a'-'z').
  - 52..61 -> 0x30+(v-52) ('0'-'9').
  - 62 -> 0x2B ('+').
  - 63 -> 0x2F ('/').
- Purely combinational map, registered into bas together with out; one-cycle latency from the completing bit.
- No '=' padding characters are emitted.
- len=0: no bit is ever accepted; outputs stay at reset values.

Optional Feature:
- Macro B64_URLSAFE_EN.
- Defined: map(62)=0x2D ('-') and map(63)=0x5F ('_').
- Undefined: standard alphabet, 62='+' (0x2B) and 63='/' (0x2F).
- All other codes are identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles mid-activity -> ascii=0, bas=0, out=0. Next accepted bit starts a fresh char and sextet.
- Stream 98'b1000011_1001111_1001101_1010000_0110011_0110001_0110001_1011111_1101001_1110011_1011111_1100110_1110101_1101110 with len=98, index counting 97..0:
  - After bit 7: ascii=0x43 'C'.
  - ascii then steps through "COMP311_is_fun"; final ascii=0x6E 'n'.
- Same stream, sextet path:
  - Sextet 1 = 100001 -> out=33, bas=0x68 'h'.
  - Sextet 2 = 110011 -> out=51, bas=0x7A 'z'.
  - Sextet 3 = 111001 -> out=57, bas=0x35 '5'.
- Final partial: trailing 2 bits "10" at index=0 -> out=32 (100000), bas=0x67 'g'.
  - done set; further index values (wrap to 1023, X bit_in) change nothing.
- Out-of-range index: index=len, or index>len, with toggling bit_in -> no output or counter change.
- Alphabet edges: stream 111110_111111 -> out=62, bas=0x2B, then out=63, bas=0x2F. With B64_URLSAFE_EN: 0x2D then 0x5F.
